// File: rtl/cpu_pkg.sv
// Shared datapath widths, ALU opcodes and the ID/EX control bundle.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam int RAW  = 5;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    typedef struct packed {
        logic           valid;
        logic           reg_write;
        logic           mem_read;
        logic           mem_write;
        logic [RAW-1:0] rd;
        logic [3:0]     alu_ctrl;
        logic           use_imm;
    } id_ex_ctrl_t;

    // All-zero bundle: invalid, no side effects, ALU op ADD.
    localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Per-operand forwarding select: EX/MEM first, then MEM/WB, else register file.
module fwd_mux
    import cpu_pkg::*;
(
    input  logic [RAW-1:0]  rs,
    input  logic [XLEN-1:0] regdata,
    input  logic [RAW-1:0]  exm_rd,
    input  logic            exm_reg_write,
    input  logic [XLEN-1:0] exm_result,
    input  logic [RAW-1:0]  mwb_rd,
    input  logic            mwb_reg_write,
    input  logic [XLEN-1:0] mwb_result,
    output logic [XLEN-1:0] fwd
);

    logic exm_hit;
    logic mwb_hit;

    assign exm_hit = exm_reg_write && (exm_rd != '0) && (exm_rd == rs);
    assign mwb_hit = mwb_reg_write && (mwb_rd != '0) && (mwb_rd == rs);

    always_comb begin
        fwd = regdata;
        if (exm_hit)
            fwd = exm_result;
        else if (mwb_hit)
            fwd = mwb_result;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, ALU operand placement
// and load-use bubble insertion.
module id_ex_stage
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [RAW-1:0]  id_rs1,
    input  logic [RAW-1:0]  id_rs2,
    input  logic [RAW-1:0]  id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [3:0]      id_alu_ctrl,
    input  logic            id_use_imm,
    input  logic            id_reg_write,
    input  logic            id_mem_read,
    input  logic            id_mem_write,
    input  logic            stall,
    input  logic            flush,
    input  logic [RAW-1:0]  exm_rd,
    input  logic            exm_reg_write,
    input  logic [XLEN-1:0] exm_result,
    input  logic [RAW-1:0]  mwb_rd,
    input  logic            mwb_reg_write,
    input  logic [XLEN-1:0] mwb_result,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    output logic            ex_valid,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic [RAW-1:0]  ex_rd,
    output logic [XLEN-1:0] ex_store_data,
    output logic            load_use_hazard
);

    id_ex_ctrl_t     ctrl_q;
    id_ex_ctrl_t     id_ctrl;
    logic [RAW-1:0]  rs1_q;
    logic [RAW-1:0]  rs2_q;
    logic [XLEN-1:0] rs1_data_q;
    logic [XLEN-1:0] rs2_data_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    assign load_use_hazard = ctrl_q.valid && ctrl_q.mem_read && (ctrl_q.rd != '0) &&
                             id_valid && ((id_rs1 == ctrl_q.rd) || (id_rs2 == ctrl_q.rd));

    // Side-effecting control bits only survive for a real instruction.
    always_comb begin
        id_ctrl           = CTRL_BUBBLE;
        id_ctrl.valid     = id_valid;
        id_ctrl.reg_write = id_valid && id_reg_write;
        id_ctrl.mem_read  = id_valid && id_mem_read;
        id_ctrl.mem_write = id_valid && id_mem_write;
        id_ctrl.rd        = id_rd;
        id_ctrl.alu_ctrl  = id_alu_ctrl;
        id_ctrl.use_imm   = id_use_imm;
    end

    // Bubbles still take in the data fields; only control is cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q     <= CTRL_BUBBLE;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
        end else if (flush || !stall) begin
            ctrl_q     <= (flush || load_use_hazard) ? CTRL_BUBBLE : id_ctrl;
            rs1_q      <= id_rs1;
            rs2_q      <= id_rs2;
            rs1_data_q <= id_rs1_data;
            rs2_data_q <= id_rs2_data;
            imm_q      <= id_imm;
        end
    end

    fwd_mux u_fwd_rs1 (
        .rs            (rs1_q),
        .regdata       (rs1_data_q),
        .exm_rd        (exm_rd),
        .exm_reg_write (exm_reg_write),
        .exm_result    (exm_result),
        .mwb_rd        (mwb_rd),
        .mwb_reg_write (mwb_reg_write),
        .mwb_result    (mwb_result),
        .fwd           (fwd_rs1)
    );

    fwd_mux u_fwd_rs2 (
        .rs            (rs2_q),
        .regdata       (rs2_data_q),
        .exm_rd        (exm_rd),
        .exm_reg_write (exm_reg_write),
        .exm_result    (exm_result),
        .mwb_rd        (mwb_rd),
        .mwb_reg_write (mwb_reg_write),
        .mwb_result    (mwb_result),
        .fwd           (fwd_rs2)
    );

    // The ALU shifts b by a[4:0], so shifts swap the usual operand roles.
    always_comb begin
        alu_a = fwd_rs1;
        alu_b = ctrl_q.use_imm ? imm_q : fwd_rs2;
        if (is_shift(ctrl_q.alu_ctrl)) begin
            alu_b = fwd_rs1;
            alu_a = ctrl_q.use_imm ? {{(XLEN-5){1'b0}}, imm_q[4:0]} : fwd_rs2;
        end else if (ctrl_q.alu_ctrl == ALU_LUI) begin
            alu_b = imm_q;
        end
    end

    assign alu_ctrl      = ctrl_q.alu_ctrl;
    assign ex_valid      = ctrl_q.valid;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_rd         = ctrl_q.rd;
    assign ex_store_data = fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: forwarding, operand placement, hazards, stall/flush.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm;
    logic [3:0]  id_alu_ctrl;
    logic        id_use_imm, id_reg_write, id_mem_read, id_mem_write;
    logic        stall, flush;
    logic [4:0]  exm_rd, mwb_rd;
    logic        exm_reg_write, mwb_reg_write;
    logic [31:0] exm_result, mwb_result;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_ctrl;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [4:0]  ex_rd;
    logic        load_use_hazard;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_ctrl(id_alu_ctrl), .id_use_imm(id_use_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .stall(stall), .flush(flush),
        .exm_rd(exm_rd), .exm_reg_write(exm_reg_write), .exm_result(exm_result),
        .mwb_rd(mwb_rd), .mwb_reg_write(mwb_reg_write), .mwb_result(mwb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_rd(ex_rd), .ex_store_data(ex_store_data),
        .load_use_hazard(load_use_hazard)
    );

    task automatic clear_inputs();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_alu_ctrl = 4'b0000;
        id_use_imm = 0; id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        stall = 0; flush = 0;
        exm_rd = 0; exm_reg_write = 0; exm_result = 0;
        mwb_rd = 0; mwb_reg_write = 0; mwb_result = 0;
    endtask

    task automatic set_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                             input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                             input logic [3:0] op, input logic use_imm, input logic rw,
                             input logic mr, input logic mw);
        id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_ctrl = op;
        id_use_imm = use_imm; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1;
        #12;
        checks++; if (ex_valid !== 1'b0 || alu_ctrl !== 4'b0000) begin errors++;
            $display("FAIL reset_ctrl: ex_valid=%b alu_ctrl=%b, want 0 0000", ex_valid, alu_ctrl); end
        checks++; if (alu_a !== 32'h0 || alu_b !== 32'h0 || ex_store_data !== 32'h0 || ex_rd !== 5'd0) begin errors++;
            $display("FAIL reset_data: a=%h b=%h sd=%h rd=%0d, want all 0", alu_a, alu_b, ex_store_data, ex_rd); end
        @(negedge clk);
        rst = 0;
        // Mid-stream reset: get a valid instruction into EX, then pulse rst between edges.
        set_instr(5'd1, 5'd2, 5'd7, 32'h11, 32'h22, 32'h0, 4'b0100, 0, 1, 0, 0);
        step();
        checks++; if (ex_valid !== 1'b1 || alu_ctrl !== 4'b0100 || ex_rd !== 5'd7) begin errors++;
            $display("FAIL reset_prefill: valid=%b ctrl=%b rd=%0d, want 1 0100 7", ex_valid, alu_ctrl, ex_rd); end
        #2 rst = 1;
        #1;
        checks++; if (ex_valid !== 1'b0 || alu_ctrl !== 4'b0000 || ex_reg_write !== 1'b0) begin errors++;
            $display("FAIL reset_async: valid=%b ctrl=%b rw=%b, want 0 0000 0", ex_valid, alu_ctrl, ex_reg_write); end
        @(negedge clk);
        rst = 0;
        step();
        checks++; if (ex_valid !== 1'b1 || alu_a !== 32'h11 || alu_b !== 32'h22) begin errors++;
            $display("FAIL reset_release_capture: valid=%b a=%h b=%h, want 1 11 22", ex_valid, alu_a, alu_b); end
    endtask

    task automatic test_forward();
        @(negedge clk);
        clear_inputs();
        set_instr(5'd3, 5'd9, 5'd10, 32'h5, 32'h1, 32'h0, 4'b0000, 0, 1, 0, 0);
        exm_rd = 5'd3; exm_reg_write = 1; exm_result = 32'h10;
        step();
        checks++; if (alu_a !== 32'h10 || alu_b !== 32'h1 || alu_ctrl !== 4'b0000) begin errors++;
            $display("FAIL fwd_exm_add: a=%h b=%h ctrl=%b, want 10 1 0000", alu_a, alu_b, alu_ctrl); end
        @(negedge clk);
        set_instr(5'd4, 5'd4, 5'd11, 32'h1, 32'h2, 32'h0, 4'b0010, 0, 1, 0, 1);
        exm_rd = 5'd4; exm_reg_write = 1; exm_result = 32'hAA;
        mwb_rd = 5'd4; mwb_reg_write = 1; mwb_result = 32'hBB;
        step();
        checks++; if (alu_a !== 32'hAA || alu_b !== 32'hAA || ex_store_data !== 32'hAA) begin errors++;
            $display("FAIL fwd_double_match: a=%h b=%h sd=%h, want AA AA AA", alu_a, alu_b, ex_store_data); end
        // Drop EX/MEM; MEM/WB now wins on the same registered instruction.
        exm_reg_write = 0;
        #1;
        checks++; if (alu_a !== 32'hBB || ex_store_data !== 32'hBB) begin errors++;
            $display("FAIL fwd_mwb_only: a=%h sd=%h, want BB BB", alu_a, ex_store_data); end
        @(negedge clk);
        clear_inputs();
        set_instr(5'd0, 5'd0, 5'd12, 32'h33, 32'h44, 32'h0, 4'b0101, 0, 1, 0, 0);
        exm_rd = 5'd0; exm_reg_write = 1; exm_result = 32'hDEAD;
        mwb_rd = 5'd0; mwb_reg_write = 1; mwb_result = 32'hBEEF;
        step();
        checks++; if (alu_a !== 32'h33 || alu_b !== 32'h44) begin errors++;
            $display("FAIL fwd_r0: a=%h b=%h, want 33 44", alu_a, alu_b); end
    endtask

    task automatic test_operands();
        @(negedge clk);
        clear_inputs();
        set_instr(5'd1, 5'd2, 5'd3, 32'h80000000, 32'h77, 32'hFFFFFFE4, 4'b1111, 1, 1, 0, 0);
        step();
        checks++; if (alu_b !== 32'h80000000 || alu_a !== 32'h4 || alu_ctrl !== 4'b1111) begin errors++;
            $display("FAIL sra_imm: a=%h b=%h ctrl=%b, want 4 80000000 1111", alu_a, alu_b, alu_ctrl); end
        @(negedge clk);
        set_instr(5'd1, 5'd2, 5'd3, 32'h3, 32'h8, 32'h1F, 4'b0011, 0, 1, 0, 0);
        step();
        checks++; if (alu_a !== 32'h8 || alu_b !== 32'h3) begin errors++;
            $display("FAIL sll_reg: a=%h b=%h, want 8 3", alu_a, alu_b); end
        @(negedge clk);
        set_instr(5'd1, 5'd2, 5'd3, 32'h9, 32'h8, 32'h12345000, 4'b0110, 1, 1, 0, 0);
        step();
        checks++; if (alu_a !== 32'h9 || alu_b !== 32'h12345000) begin errors++;
            $display("FAIL lui: a=%h b=%h, want 9 12345000", alu_a, alu_b); end
        @(negedge clk);
        set_instr(5'd1, 5'd2, 5'd3, 32'h9, 32'h8, 32'hFFFFFFF0, 4'b0001, 1, 1, 0, 0);
        step();
        checks++; if (alu_a !== 32'h9 || alu_b !== 32'hFFFFFFF0 || ex_store_data !== 32'h8) begin errors++;
            $display("FAIL and_imm: a=%h b=%h sd=%h, want 9 FFFFFFF0 8", alu_a, alu_b, ex_store_data); end
        @(negedge clk);
        set_instr(5'd1, 5'd2, 5'd3, 32'h9, 32'h8, 32'h0, 4'b1011, 0, 1, 0, 0);
        step();
        checks++; if (alu_ctrl !== 4'b1011 || alu_a !== 32'h9 || alu_b !== 32'h8) begin errors++;
            $display("FAIL unlisted_op: ctrl=%b a=%h b=%h, want 1011 9 8", alu_ctrl, alu_a, alu_b); end
        @(negedge clk);
        set_instr(5'd1, 5'd2, 5'd3, 32'h9, 32'h8, 32'h0, 4'b0000, 0, 1, 1, 1);
        id_valid = 0;
        step();
        checks++; if (ex_valid !== 0 || ex_reg_write !== 0 || ex_mem_read !== 0 || ex_mem_write !== 0) begin errors++;
            $display("FAIL invalid_ctrl: v=%b rw=%b mr=%b mw=%b, want 0 0 0 0", ex_valid, ex_reg_write, ex_mem_read, ex_mem_write); end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        clear_inputs();
        set_instr(5'd2, 5'd0, 5'd5, 32'h1000, 32'h0, 32'h4, 4'b0000, 1, 1, 1, 0);
        step();
        checks++; if (ex_mem_read !== 1 || ex_rd !== 5'd5) begin errors++;
            $display("FAIL lu_load_in_ex: mr=%b rd=%0d, want 1 5", ex_mem_read, ex_rd); end
        @(negedge clk);
        set_instr(5'd5, 5'd1, 5'd6, 32'h0, 32'h3, 32'h0, 4'b0000, 0, 1, 0, 0);
        #1;
        checks++; if (load_use_hazard !== 1'b1) begin errors++;
            $display("FAIL lu_detect: hazard=%b, want 1", load_use_hazard); end
        step();
        checks++; if (ex_valid !== 0 || ex_reg_write !== 0 || ex_rd !== 5'd0 || load_use_hazard !== 0) begin errors++;
            $display("FAIL lu_bubble: v=%b rw=%b rd=%0d hz=%b, want 0 0 0 0", ex_valid, ex_reg_write, ex_rd, load_use_hazard); end
        @(negedge clk);
        mwb_rd = 5'd5; mwb_reg_write = 1; mwb_result = 32'h55;
        step();
        checks++; if (ex_valid !== 1 || ex_rd !== 5'd6 || alu_a !== 32'h55 || alu_b !== 32'h3) begin errors++;
            $display("FAIL lu_capture: v=%b rd=%0d a=%h b=%h, want 1 6 55 3", ex_valid, ex_rd, alu_a, alu_b); end
    endtask

    task automatic test_stall_flush();
        @(negedge clk);
        clear_inputs();
        set_instr(5'd1, 5'd2, 5'd8, 32'hA1, 32'hB2, 32'h0, 4'b0100, 0, 1, 0, 0);
        step();
        @(negedge clk);
        set_instr(5'd3, 5'd4, 5'd9, 32'hC3, 32'hD4, 32'h0, 4'b0101, 0, 1, 0, 0);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (ex_valid !== 1 || ex_rd !== 5'd8 || alu_a !== 32'hA1 || alu_b !== 32'hB2 || alu_ctrl !== 4'b0100) begin errors++;
                $display("FAIL stall_hold[%0d]: v=%b rd=%0d a=%h b=%h ctrl=%b, want 1 8 A1 B2 0100", i, ex_valid, ex_rd, alu_a, alu_b, alu_ctrl); end
        end
        @(negedge clk);
        stall = 0;
        step();
        checks++; if (ex_rd !== 5'd9 || alu_a !== 32'hC3 || alu_ctrl !== 4'b0101) begin errors++;
            $display("FAIL stall_release: rd=%0d a=%h ctrl=%b, want 9 C3 0101", ex_rd, alu_a, alu_ctrl); end
        @(negedge clk);
        stall = 1; flush = 1;
        step();
        checks++; if (ex_valid !== 0 || ex_reg_write !== 0 || ex_rd !== 5'd0 || alu_ctrl !== 4'b0000) begin errors++;
            $display("FAIL flush_over_stall: v=%b rw=%b rd=%0d ctrl=%b, want 0 0 0 0000", ex_valid, ex_reg_write, ex_rd, alu_ctrl); end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_operands();
        test_load_use();
        test_stall_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
